fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the next-generation CPU core. It replaces the fixed PC register, PC+4 adder and jump/branch PC mux path with a decoupled fetch stage. It issues in-order requests to a latency-tolerant instruction memory and buffers returned words in a DEPTH-entry prefetch queue. Instructions are handed to decode over a valid/ready handshake, and a single redirect port absorbs branches and jumps, flushing the queue and in-flight fetches.

## Interface
- XLEN, 32: PC/address width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2; also the maximum number of outstanding memory requests.
- RESET_PC, 0: PC loaded by reset.
- PC_STEP, 4: byte increment per instruction.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  run enable; fetching begins the cycle after start_i is sampled high.
- imem_req_o  in→out  1  request strobe; one request per high cycle (memory always accepts).
- imem_addr_o  out  XLEN  request address.
- imem_rvalid_i  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  branch/jump taken; overrides everything else.
- redirect_pc_i  in  XLEN  new fetch PC.
- inst_valid_o  out  1  queue head valid.
- inst_ready_i  in  1  decode accepts head.
- inst_o  out  32  head instruction.
- inst_pc_o  out  XLEN  head PC.
- inst_pc4_o  out  XLEN  head PC + PC_STEP, for link/branch-base use.
- busy_o  out  1  outstanding requests non-zero.

## Operation
- FSM:
  - IDLE: reset state; no requests.
  - IDLE→RUN when start_i=1.
  - RUN held until rst_i; start_i ignored in RUN.
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of next accepted response.
  - outstanding: 0..DEPTH.
  - discard: 0..DEPTH.
  - queue count.
- Issue:
  - imem_req_o = RUN & !redirect_i & (count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc.
  - On issue, fetch_pc += PC_STEP (mod 2^XLEN) and outstanding +1.
- Response:
  - Every imem_rvalid_i decrements outstanding.
  - If discard>0: word dropped, discard −1.
  - Else: word pushed with tag resp_pc, then resp_pc += PC_STEP.
  - rvalid with outstanding=0 is ignored (no state change).
- Pop: inst_valid_o & inst_ready_i.
- inst_valid_o = (count≠0) & !redirect_i.
- Redirect cycle:
  - Queue cleared; fetch_pc and resp_pc ← redirect_pc_i.
  - discard ← outstanding after this cycle's response is removed; a response arriving this cycle is dropped.
  - No issue and no pop this cycle.
  - Redirect in IDLE loads the PCs only.
- Credit rule guarantees no push into a full queue; push and pop in the same cycle leave count unchanged.
- Reset values:
  - IDLE; fetch_pc = resp_pc = RESET_PC; count = outstanding = discard = 0.
  - imem_req_o = 0, inst_valid_o = 0, busy_o = 0.
  - imem_addr_o = RESET_PC, inst_o = 0, inst_pc_o = 0, inst_pc4_o = PC_STEP.

## Timing
- Cycle n: start_i sampled. Cycle n+1: first request (RESET_PC).
- With 1-cycle memory, rvalid arrives at n+2 and inst_valid_o rises at n+3; the queue output is registered with no bypass.
- Sustained throughput: 1 instr/cycle when memory latency L ≤ DEPTH−1.
- Redirect at cycle r: first new-target request at r+1; earliest valid at r+3 with L=1.
- Accepted head advances the next cycle.
- The only combinational paths are redirect_i→inst_valid_o and redirect_i→imem_req_o.
- Counters wrap never; PCs wrap modulo 2^XLEN.

## Structure
- cpu_pkg holds:
  - XLEN default.
  - INST_W=32.
  - PC_STEP default.
  - RESET_PC default.
  - Fetch state enum (IDLE, RUN).
- Sub-module fetch_queue:
  - Synchronous FIFO of {pc, inst}, width XLEN+32, depth DEPTH.
  - push/pop/clear/count; pointer wrap via log2(DEPTH) bits.

## Test plan
- Reset then start_i=1 at cycle 2, 1-cycle memory returning addr as data, ready=1 → requests at 0,4,8,…; inst_pc_o sequence 0,4,8 with inst_o = inst_pc_o; first valid at cycle 5.
- inst_ready_i=0 with DEPTH=4, L=1 → exactly 4 requests, count=4, imem_req_o stays 0; raising ready drains 4 entries then refills with no drop or duplicate.
- L=3 memory, redirect_i to 0x100 while 3 requests are outstanding → those 3 responses discarded, next inst_pc_o=0x100, inst_pc4_o=0x104.
- Redirect coincident with rvalid and with inst_ready_i=1 → no pop, response dropped, queue empty next cycle.
- fetch_pc at 2^XLEN−4 → next request address 0 (wrap).
- rst_i asserted mid-stream with 2 outstanding → all outputs at reset values next cycle; stray rvalids ignored; restart fetches from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the fetch controller state type.
// Design defaults live here so the core and its benches agree on them.
package cpu_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          INST_W       = 32;
    localparam int          PC_STEP_DEF  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory, redirect and decode handshake signals.
// master = the fetch unit itself, slave = memory/decode/branch side.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic              imem_req_o;
    logic [XLEN-1:0]   imem_addr_o;
    logic              imem_rvalid_i;
    logic [INST_W-1:0] imem_rdata_i;
    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [XLEN-1:0]   inst_pc_o;
    logic [XLEN-1:0]   inst_pc4_o;
    logic              busy_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_o,
        output inst_pc_o,
        output inst_pc4_o,
        output busy_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_o,
        input  inst_pc_o,
        input  inst_pc4_o,
        input  busy_o
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, inst} entries; DEPTH must be a power of two.
// Head is read straight from registered storage, so a push is visible the next cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~i_clear;
    assign w_pop  = i_pop & ~i_clear & (r_count != '0);

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: in-order requests to a latency-tolerant memory,
// a credit-limited prefetch queue, and a redirect port that flushes everything.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    fetch_unit_if.master  bus
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [XLEN-1:0]       r_fetch_pc;
    logic [XLEN-1:0]       r_resp_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;

    logic [CW-1:0]         w_count;
    logic [XLEN+INST_W-1:0] w_head;
    logic [CW:0]           w_credit_used;
    logic                  w_issue;
    logic                  w_rsp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_nonempty;
    logic [XLEN-1:0]       w_inst_pc;
    logic [INST_W-1:0]     w_inst;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Credits cover queue entries plus in-flight requests, so a response
    // always finds a free slot even if decode stalls indefinitely.
    always_comb begin
        w_state_nxt   = r_state;
        w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
        w_issue       = 1'b0;
        w_rsp         = 1'b0;
        w_push        = 1'b0;
        w_nonempty    = (w_count != '0);
        w_valid       = 1'b0;
        w_pop         = 1'b0;

        if (r_state == ST_IDLE && start_i) begin
            w_state_nxt = ST_RUN;
        end

        w_issue = (r_state == ST_RUN) && !bus.redirect_i && (w_credit_used < DEPTH_C);
        w_rsp   = bus.imem_rvalid_i && (r_outstanding != '0);
        w_push  = w_rsp && !bus.redirect_i && (r_discard == '0);
        w_valid = w_nonempty && !bus.redirect_i;
        w_pop   = w_valid && bus.inst_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp);
            if (bus.redirect_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= bus.redirect_pc_i;
                r_resp_pc  <= bus.redirect_pc_i;
                r_discard  <= r_outstanding - CW'(w_rsp);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + STEP;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + INST_W)
    ) u_queue (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.redirect_i),
        .i_data  ({r_resp_pc, bus.imem_rdata_i}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // Empty queue presents zeros so the head fields are defined out of reset.
    assign w_inst_pc = w_nonempty ? w_head[XLEN+INST_W-1:INST_W] : '0;
    assign w_inst    = w_nonempty ? w_head[INST_W-1:0] : '0;

    assign bus.imem_req_o   = w_issue;
    assign bus.imem_addr_o  = r_fetch_pc;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_inst;
    assign bus.inst_pc_o    = w_inst_pc;
    assign bus.inst_pc4_o   = w_inst_pc + STEP;
    assign bus.busy_o       = (r_outstanding != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns the request address as data
// after a selectable latency; expectations are hand-derived cycle by cycle.
module tb_fetch_unit;

    logic clk;
    logic rst;
    logic start;
    logic mem_flush;
    logic [1:0] lat_m1;
    int   n_tests;
    int   n_fail;
    int   req_cnt;
    int   req_base;
    int   wk;

    logic        pipe_v [4];
    logic [31:0] pipe_a [4];

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial req_cnt = 0;
    always @(posedge clk) begin
        if (bus.imem_req_o) req_cnt <= req_cnt + 1;
    end

    always @(posedge clk) begin
        if (mem_flush) begin
            for (int k = 0; k < 4; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_a[k] <= 32'h0;
            end
        end else begin
            pipe_v[0] <= bus.imem_req_o;
            pipe_a[0] <= bus.imem_addr_o;
            for (int k = 1; k < 4; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_a[k] <= pipe_a[k-1];
            end
        end
    end

    assign bus.imem_rvalid_i = pipe_v[lat_m1];
    assign bus.imem_rdata_i  = pipe_a[lat_m1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_req"},   32'(bus.imem_req_o),   32'h0);
        check({p, "_valid"}, 32'(bus.inst_valid_o), 32'h0);
        check({p, "_busy"},  32'(bus.busy_o),       32'h0);
        check({p, "_addr"},  bus.imem_addr_o,       32'h0);
        check({p, "_inst"},  bus.inst_o,            32'h0);
        check({p, "_pc"},    bus.inst_pc_o,         32'h0);
        check({p, "_pc4"},   bus.inst_pc4_o,        32'h4);
    endtask

    // Called right after step(); checks each accepted head against a running PC.
    task automatic drain(input int n, input logic [31:0] start_pc);
        logic [31:0] exp;
        int got;
        exp = start_pc;
        got = 0;
        for (int k = 0; k < 4 * n && got < n; k++) begin
            mid();
            if (bus.inst_valid_o && bus.inst_ready_i) begin
                check("pop_pc",   bus.inst_pc_o, exp);
                check("pop_inst", bus.inst_o,    exp);
                exp = exp + 32'h4;
                got++;
            end
            step();
        end
        check("pop_count", 32'(got), 32'(n));
    endtask

    task automatic quiesce(input int new_lat);
        bus.inst_ready_i = 1'b0;
        repeat (10) step();
        mid();
        check("quiet_busy", 32'(bus.busy_o),     32'h0);
        check("quiet_req",  32'(bus.imem_req_o), 32'h0);
        step();
        lat_m1 = 2'(new_lat - 1);
        repeat (4) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        start = 1'b0;
        mem_flush = 1'b1;
        lat_m1 = 2'd0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.inst_ready_i = 1'b0;

        // reset values
        repeat (3) step();
        mid();
        reset_checks("rst");

        // basic stream, L=1, start sampled in cycle 2
        step(); rst = 1'b0; mem_flush = 1'b0;
        mid();
        check("idle_req", 32'(bus.imem_req_o), 32'h0);
        step();
        step(); start = 1'b1; bus.inst_ready_i = 1'b1;
        mid();
        check("pre_start_req", 32'(bus.imem_req_o), 32'h0);
        step(); start = 1'b0;
        mid();
        check("first_req",  32'(bus.imem_req_o), 32'h1);
        check("first_addr", bus.imem_addr_o,     32'h0);
        step();
        mid();
        check("c4_valid", 32'(bus.inst_valid_o), 32'h0);
        check("c4_addr",  bus.imem_addr_o,        32'h4);
        step();
        mid();
        check("c5_valid", 32'(bus.inst_valid_o), 32'h1);
        check("c5_pc",    bus.inst_pc_o,          32'h0);
        check("c5_inst",  bus.inst_o,             32'h0);
        check("c5_pc4",   bus.inst_pc4_o,         32'h4);
        check("c5_addr",  bus.imem_addr_o,        32'h8);
        step();
        mid();
        check("c6_pc",   bus.inst_pc_o, 32'h4);
        check("c6_inst", bus.inst_o,    32'h4);
        step();
        mid();
        check("c7_pc", bus.inst_pc_o, 32'h8);

        // backpressure: redirect to 0x200 with decode stalled
        step(); bus.inst_ready_i = 1'b0; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
        req_base = req_cnt;
        mid();
        check("redir_valid", 32'(bus.inst_valid_o), 32'h0);
        check("redir_req",   32'(bus.imem_req_o),   32'h0);
        step(); bus.redirect_i = 1'b0;
        repeat (8) step();
        mid();
        check("stall_reqs",  32'(req_cnt - req_base), 32'h4);
        check("stall_req",   32'(bus.imem_req_o),     32'h0);
        check("stall_valid", 32'(bus.inst_valid_o),   32'h1);
        check("stall_pc",    bus.inst_pc_o,           32'h200);
        check("stall_addr",  bus.imem_addr_o,         32'h210);
        step(); bus.inst_ready_i = 1'b1;
        drain(12, 32'h200);

        // L=3: redirect while three requests are in flight
        quiesce(3);
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h80;
        step(); bus.redirect_i = 1'b0;
        step();
        step();
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
        mid();
        check("l3_redir_req",   32'(bus.imem_req_o),   32'h0);
        check("l3_redir_valid", 32'(bus.inst_valid_o), 32'h0);
        check("l3_redir_busy",  32'(bus.busy_o),       32'h1);
        step(); bus.redirect_i = 1'b0;
        wk = 0;
        while (wk < 12) begin
            mid();
            if (bus.inst_valid_o) break;
            step();
            wk++;
        end
        check("l3_valid", 32'(bus.inst_valid_o), 32'h1);
        check("l3_lat",   32'(wk),               32'h4);
        check("l3_pc",    bus.inst_pc_o,         32'h100);
        check("l3_inst",  bus.inst_o,            32'h100);
        check("l3_pc4",   bus.inst_pc4_o,        32'h104);
        step(); bus.inst_ready_i = 1'b1;
        drain(4, 32'h100);

        // redirect coincident with rvalid and ready: no pop, response dropped
        quiesce(1);
        step(); bus.inst_ready_i = 1'b1;
        repeat (8) step();
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300;
        mid();
        check("co_valid", 32'(bus.inst_valid_o), 32'h0);
        check("co_req",   32'(bus.imem_req_o),   32'h0);
        check("co_busy",  32'(bus.busy_o),       32'h1);
        step(); bus.redirect_i = 1'b0;
        mid();
        check("co_drop",  32'(bus.inst_valid_o), 32'h0);
        check("co_req1",  32'(bus.imem_req_o),   32'h1);
        check("co_addr1", bus.imem_addr_o,       32'h300);
        step();
        mid();
        check("co_valid2", 32'(bus.inst_valid_o), 32'h0);
        check("co_addr2",  bus.imem_addr_o,        32'h304);
        step();
        mid();
        check("co_valid3", 32'(bus.inst_valid_o), 32'h1);
        check("co_pc3",    bus.inst_pc_o,          32'h300);
        check("co_inst3",  bus.inst_o,             32'h300);
        step();
        mid();
        check("co_pc4", bus.inst_pc_o, 32'h304);

        // PC wrap at the top of the address space
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8;
        step(); bus.redirect_i = 1'b0;
        mid();
        check("wrap_a0", bus.imem_addr_o, 32'hFFFF_FFF8);
        step();
        mid();
        check("wrap_a1", bus.imem_addr_o, 32'hFFFF_FFFC);
        step();
        mid();
        check("wrap_a2",  bus.imem_addr_o, 32'h0);
        check("wrap_pc0", bus.inst_pc_o,   32'hFFFF_FFF8);
        step();
        mid();
        check("wrap_pc1",  bus.inst_pc_o,  32'hFFFF_FFFC);
        check("wrap_pc4",  bus.inst_pc4_o, 32'h0);
        check("wrap_inst", bus.inst_o,     32'hFFFF_FFFC);

        // reset mid-stream with two outstanding (L=2), stray responses after it
        quiesce(2);
        step(); bus.inst_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
        step(); bus.redirect_i = 1'b0;
        repeat (8) step();
        mid();
        check("pre_rst_busy", 32'(bus.busy_o), 32'h1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        mid();
        reset_checks("rst2");
        repeat (2) begin
            step();
            mid();
            check("stray_valid", 32'(bus.inst_valid_o), 32'h0);
            check("stray_busy",  32'(bus.busy_o),       32'h0);
            check("stray_req",   32'(bus.imem_req_o),   32'h0);
        end
        step(); start = 1'b1;
        step(); start = 1'b0;
        mid();
        check("restart_req",  32'(bus.imem_req_o), 32'h1);
        check("restart_addr", bus.imem_addr_o,     32'h0);
        step();
        drain(3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
